// File: rtl/vga_fb_arbiter_if.sv
// MCU-side framebuffer bus: request/ack handshake with address, write data and read data.
interface vga_fb_arbiter_if;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [14:0] MEM_ADDR;
    logic [7:0]  MEM_WDATA;
    logic        MEM_ACK;
    logic [7:0]  MEM_RDATA;

    modport master (
        output MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
        input  MEM_ACK, MEM_RDATA
    );

    modport slave (
        input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
        output MEM_ACK, MEM_RDATA
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Shares a single-port 160x120 framebuffer between VGA prefetch (4x scaled) and the MCU bus.
// Display slots always win; the MCU gets every other cycle, one access per two cycles.
module vga_fb_arbiter #(
    parameter int H_TOTAL   = 800,
    parameter int H_VISIBLE = 640,
    parameter int V_TOTAL   = 525,
    parameter int V_VISIBLE = 480,
    parameter int FB_WIDTH  = 160,
    parameter int FB_HEIGHT = 120
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [9:0]          ROW,
    input  logic [9:0]          COLUMN,
    output logic [3:0]          RED,
    output logic [3:0]          GREEN,
    output logic [3:0]          BLUE,
    vga_fb_arbiter_if.slave     mem,
    output logic [14:0]         FB_ADDR,
    output logic                FB_WE,
    output logic [7:0]          FB_WDATA,
    input  logic [7:0]          FB_RDATA
);

    localparam logic [9:0]  C_PRE_END = 10'(H_VISIBLE - 4);
    localparam logic [9:0]  C_H_LAST2 = 10'(H_TOTAL - 2);
    localparam logic [9:0]  C_V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0]  C_V_VIS   = 10'(V_VISIBLE);
    localparam logic [14:0] C_DEPTH   = 15'(FB_WIDTH * FB_HEIGHT);

    typedef enum logic {IDLE, ACK} state_t;

    state_t      r_state;
    logic        r_mem_ack;
    logic        r_rd_ok;
    logic        r_slot_d;
    logic [7:0]  r_pix;
    logic [14:0] r_fb_addr;

    logic [9:0]  w_next_row;
    logic        w_vis_slot;
    logic        w_line_slot;
    logic        w_slot;
    logic [7:0]  w_fr;
    logic [7:0]  w_fc;
    logic [14:0] w_disp_addr;
    logic        w_in_range;
    logic        w_grant;

    assign w_next_row  = (ROW == C_V_LAST) ? '0 : ROW + 10'd1;
    assign w_vis_slot  = (COLUMN[1:0] == 2'd2) && (COLUMN < C_PRE_END) && (ROW < C_V_VIS);
    assign w_line_slot = (COLUMN == C_H_LAST2) && (w_next_row < C_V_VIS);
    assign w_slot      = w_vis_slot || w_line_slot;

    // Fetch the pixel of the next 4-column group; at line end, column 0 of the next row.
    assign w_fr        = w_line_slot ? w_next_row[9:2] : ROW[9:2];
    assign w_fc        = w_line_slot ? '0 : COLUMN[9:2] + 8'd1;
    assign w_disp_addr = {w_fr, 7'b0} + {2'b0, w_fr, 5'b0} + {7'b0, w_fc};

    assign w_in_range  = mem.MEM_ADDR < C_DEPTH;
    assign w_grant     = RST_N && (r_state == IDLE) && mem.MEM_REQ && !w_slot;

    always_comb begin
        FB_ADDR = r_fb_addr;
        FB_WE   = 1'b0;
        if (w_slot) begin
            FB_ADDR = w_disp_addr;
        end else if (w_grant) begin
            FB_ADDR = mem.MEM_ADDR;
            FB_WE   = mem.MEM_WE && w_in_range;
        end
    end

    assign FB_WDATA      = mem.MEM_WDATA;
    assign mem.MEM_ACK   = r_mem_ack;
    assign mem.MEM_RDATA = r_rd_ok ? FB_RDATA : '0;

    assign RED   = {r_pix[7:5], r_pix[7]};
    assign GREEN = {r_pix[4:2], r_pix[4]};
    assign BLUE  = {r_pix[1:0], r_pix[1:0]};

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state   <= IDLE;
            r_mem_ack <= 1'b0;
            r_rd_ok   <= 1'b0;
            r_slot_d  <= 1'b0;
            r_pix     <= '0;
            r_fb_addr <= '0;
        end else begin
            r_fb_addr <= FB_ADDR;
            r_slot_d  <= w_slot;
            if (r_slot_d) begin
                r_pix <= FB_RDATA;
            end
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_state   <= ACK;
                        r_mem_ack <= 1'b1;
                        r_rd_ok   <= !mem.MEM_WE && w_in_range;
                    end
                end
                ACK: begin
                    r_state   <= IDLE;
                    r_mem_ack <= 1'b0;
                    r_rd_ok   <= 1'b0;
                end
                default: begin
                    r_state   <= IDLE;
                    r_mem_ack <= 1'b0;
                    r_rd_ok   <= 1'b0;
                end
            endcase
        end
    end

endmodule
